// File: rtl/seq_chunk_adder_if.sv
// Request/response bundle for seq_chunk_adder: decode-side operation request and
// writeback-side result, each with its own valid/ready handshake.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       control;
    logic             coe;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] C;
    logic             vout;
    logic             cout;

    modport master (
        output in_valid, A, B, control, coe, out_ready,
        input  in_ready, out_valid, C, vout, cout
    );

    modport slave (
        input  in_valid, A, B, control, coe, out_ready,
        output in_ready, out_valid, C, vout, cout
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Serial CHUNK-bit-per-cycle adder/subtractor with a persistent architectural carry flag.
// Optional macro ADDER_SAT_EN: clamp signed overflow for ADD/SUB/INC/DEC instead of wrapping.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst,
    seq_chunk_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, c_r;
    logic [2:0]       op_r;
    logic             coe_r, carry, vout_r, cflag;
    logic [CW-1:0]    cnt;

    logic             accept, last, flag_op, sub_op, raw_v;
    logic [WIDTH-1:0] b_eff, a_sh, b_sh;
    logic             cin;
    logic [CHUNK:0]   sum;

    assign accept  = (state == IDLE) && bus.in_valid;
    assign last    = (cnt == CW'(N - 1));
    assign flag_op = (bus.control[2:1] == 2'b11);
    assign sub_op  = (op_r == 3'b010) || (op_r == 3'b011) || (op_r == 3'b101);

    // Every op is reduced to A + Beff + cin; cflag is sampled here at the accept edge.
    always_comb begin
        b_eff = '0;
        cin   = 1'b0;
        case (bus.control)
            3'b000: begin b_eff = bus.B;  cin = 1'b0;   end
            3'b001: begin b_eff = bus.B;  cin = cflag;  end
            3'b010: begin b_eff = ~bus.B; cin = 1'b1;   end
            3'b011: begin b_eff = ~bus.B; cin = ~cflag; end
            3'b100: begin b_eff = '0;     cin = 1'b1;   end
            3'b101: begin b_eff = '1;     cin = 1'b0;   end
            default: begin b_eff = '0;    cin = 1'b0;   end
        endcase
    end

    assign a_sh  = a_r >> (cnt * CHUNK);
    assign b_sh  = b_r >> (cnt * CHUNK);
    assign sum   = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    // Only meaningful on the last chunk, where sum[CHUNK-1] is the result sign bit.
    assign raw_v = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[CHUNK-1] != a_r[WIDTH-1]);

`ifdef ADDER_SAT_EN
    logic sat_op;
    assign sat_op = (op_r == 3'b000) || (op_r == 3'b010) || (op_r == 3'b100) || (op_r == 3'b101);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = flag_op ? DONE : RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            c_r    <= '0;
            op_r   <= '0;
            coe_r  <= 1'b0;
            carry  <= 1'b0;
            vout_r <= 1'b0;
            cflag  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r   <= bus.A;
                        b_r   <= b_eff;
                        op_r  <= bus.control;
                        coe_r <= bus.coe;
                        carry <= cin;
                        cnt   <= '0;
                        if (flag_op) begin
                            c_r    <= bus.A;
                            vout_r <= 1'b0;
                            cflag  <= bus.control[0];
                        end
                    end
                end
                RUN: begin
                    c_r[cnt*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
                    carry <= sum[CHUNK];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        vout_r <= raw_v;
                        if (coe_r) cflag <= sum[CHUNK] ^ sub_op;
`ifdef ADDER_SAT_EN
                        if (raw_v && sat_op)
                            c_r <= {a_r[WIDTH-1], {(WIDTH-1){~a_r[WIDTH-1]}}};
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.C         = c_r;
    assign bus.vout      = vout_r;
    assign bus.cout      = cflag;
endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised, multi-cycle successor to the 16-bit ALU adder. It executes add, add-with-carry, sub, sub-with-borrow, increment and decrement on WIDTH-bit operands.
- Arithmetic is serial: CHUNK bits per clock, with the inter-chunk carry held in a register.
- The architectural carry flag is persistent, so multi-precision chains need no external state.
- Sits between the RISC decode stage and writeback; valid/ready on both sides.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK and >= 2.
- CHUNK, 4, bits processed per RUN cycle; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  high only in IDLE
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B (ignored for INC/DEC/CLRC/SETC)
- control  in  3  opcode
- coe  in  1  carry-out enable: 1 = write carry flag at completion
- out_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- C  out  WIDTH  result
- vout  out  1  signed overflow of this operation
- cout  out  1  architectural carry flag, current value

Behaviour:
- Reset: state IDLE; C=0, vout=0, cout=0, out_valid=0, in_ready=1; internal chunk carry and counter = 0.
- Reset dominates everything, including mid-RUN or DONE; any in-flight operation is discarded.
- Opcodes:
  - 000 ADD: A+B+0
  - 001 ADDC: A+B+cflag
  - 010 SUB: A+~B+1
  - 011 SUBB: A+~B+~cflag
  - 100 INC: A+1
  - 101 DEC: A+all-ones+0
  - 110 CLRC: C=A, vout=0, cflag<=0
  - 111 SETC: C=A, vout=0, cflag<=1
- CLRC/SETC write cflag regardless of coe.
- FSM states: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On edge with in_valid && in_ready, latch A, B-effective, control, coe.
  - Seed chunk carry with the op's carry-in (cflag sampled at this edge); counter=0; go to RUN.
  - CLRC/SETC skip RUN and go directly to DONE.
- RUN:
  - Each edge computes chunk[counter] = A_chunk + Beff_chunk + carry, writes it into C, updates carry, increments counter.
  - After the N-th chunk edge, go to DONE; out_valid=1.
- DONE:
  - C, vout, cout stable while out_valid && !out_ready.
  - At the edge with out_ready high: out_valid<=0, go to IDLE.
- Latency: accept at edge t0 gives out_valid=1 after edge t0+N. Minimum throughput is one op per N+2 cycles.
- Flags:
  - vout = (sign A == sign Beff) && (sign result != sign A).
  - Raw carry = carry out of the MSB chunk.
  - For ADD/ADDC/INC, cflag candidate = raw carry. For SUB/SUBB/DEC, cflag candidate = ~raw carry (1 = borrow).
  - Candidate is written to cflag on entering DONE only if the latched coe=1; otherwise cflag is unchanged.
  - cout always reflects cflag.
- C and vout do not change between DONE and the next RUN completion. Partial chunk writes during RUN are visible on C but out_valid=0.
- in_valid while not IDLE is ignored (not queued).
- Wrap-around is modulo 2^WIDTH (e.g. 0000-0001 = FFFF).

Optional Feature:
- Macro ADDER_SAT_EN.
- Defined: for ADD, SUB, INC, DEC only, when vout=1 the result is clamped on entering DONE. Positive overflow gives 0111..1; negative overflow gives 1000..0. vout is still reported as 1, and cflag updates from the raw carry as usual. ADDC/SUBB always wrap.
- Undefined: all ops wrap; no clamp logic synthesised.

Test Plan:
- WIDTH=16, CHUNK=4, coe=1, ADD 0000+0001 -> out_valid exactly 4 edges after accept, C=0001, vout=0, cout=0; in_ready low throughout.
- ADD 7F00+0300 -> C=8200, vout=1, cout=0. With ADDER_SAT_EN: C=7FFF, vout=1.
- ADD FF00+0100 coe=1 -> C=0000, cout=1. Then ADDC 000F+000F -> C=001F, cout=0. Then ADD FF00+0100 coe=0 after SETC -> C=0000, cout stays 1.
- SUB 0000-0001 -> C=FFFF, cout=1 (borrow), vout=0. Then SUBB 000F-000F -> C=FFFF, cout=1. INC 7FFF -> 8000, vout=1. DEC 0000 -> FFFF, cout=1.
- Hold out_ready=0 for 5 cycles in DONE -> C/vout/cout stable, in_ready=0, a new in_valid is ignored. out_ready=1 -> IDLE next edge.
- Assert rst at the 2nd RUN cycle -> next edge IDLE, C=0, cout=0, out_valid=0, in_ready=1; no result emitted.
